elastic_pipe_buffer: RTL and testbench

Parametrised elastic pipeline register chain that generalises the fixed-width inter-stage buffers to configurable width and depth. It adds valid/ready flow control, bubble collapse, synchronous flush and an occupancy count. It sits between any two pipeline stages, for example Decode→Execute. A stalled downstream stage back-pressures the upstream stage without losing or duplicating words, and a taken branch can squash every in-flight word in one cycle.

---
 rtl/elastic_pipe_buffer.sv | 83 ++++++++
 tb/tb_elastic_pipe_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipe_buffer.sv
// Elastic valid/ready register chain with bubble collapse, single-cycle flush
// and a registered occupancy count. Stage 0 faces the input, DEPTH-1 is the head.
module elastic_pipe_buffer #(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 3,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0]            r_v;
    logic [DEPTH-1:0][WIDTH-1:0] r_d;
    logic [CW-1:0]               r_count;

    logic [DEPTH:0]              w_rdy;
    logic [DEPTH-1:0]            w_vprev;
    logic [DEPTH-1:0][WIDTH-1:0] w_dprev;
    logic [DEPTH-1:0]            w_v_nxt;
    logic [DEPTH-1:0][WIDTH-1:0] w_d_nxt;
    logic [CW-1:0]               w_count_nxt;

    // Upstream neighbour of each stage; stage 0 is fed by the input port.
    assign w_vprev = DEPTH'({r_v, in_valid});
    assign w_dprev = (DEPTH * WIDTH)'({r_d, in_data});

    // A stage can take a word if it is empty or its own word moves on.
    always_comb begin
        w_rdy        = '0;
        w_rdy[DEPTH] = out_ready;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            w_rdy[i] = !r_v[i] | w_rdy[i+1];
        end
    end

    always_comb begin
        w_v_nxt     = r_v;
        w_d_nxt     = r_d;
        w_count_nxt = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (w_rdy[i]) begin
                w_v_nxt[i] = w_vprev[i];
                if (w_vprev[i]) begin
                    w_d_nxt[i] = w_dprev[i];
                end
            end
        end
        // Flush squashes validity only; payload registers keep their contents.
        if (flush) begin
            w_v_nxt = '0;
            w_d_nxt = r_d;
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_count_nxt = w_count_nxt + CW'(w_v_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v     <= '0;
            r_d     <= '0;
            r_count <= '0;
        end else begin
            r_v     <= w_v_nxt;
            r_d     <= w_d_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = r_v[DEPTH-1];
    assign out_data  = r_d[DEPTH-1];
    assign count     = r_count;

endmodule

// File: tb/tb_elastic_pipe_buffer.sv
// Randomised and directed bench for elastic_pipe_buffer (DEPTH=3 and DEPTH=1 builds)
// checked every cycle against a word/position queue model.
module tb_elastic_pipe_buffer;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        iv, ir, ov, orr, fl;
    logic [15:0] id, od;
    logic [1:0]  cnt;

    logic        iv1, ir1, ov1, or1, fl1;
    logic [15:0] id1, od1;
    logic [0:0]  cnt1;

    elastic_pipe_buffer #(.WIDTH(16), .DEPTH(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .in_valid(iv), .in_ready(ir), .in_data(id),
        .out_valid(ov), .out_ready(orr), .out_data(od),
        .flush(fl), .count(cnt)
    );

    elastic_pipe_buffer #(.WIDTH(16), .DEPTH(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .flush(fl1), .count(cnt1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: held words oldest first, each with its stage position (DEPTH-1 = head).
    int          mpos[2][4];
    logic [15:0] mdat[2][4];
    int          mcnt[2] = '{0, 0};

    function automatic logic m_ir(input int k, input int depth, input logic o_rdy);
        return (mcnt[k] < depth) || o_rdy;
    endfunction

    function automatic logic m_ov(input int k, input int depth);
        return (mcnt[k] > 0) && (mpos[k][0] == depth - 1);
    endfunction

    task automatic model_step(input int k, input int depth, input logic i_v,
                              input logic o_rdy, input logic f, input logic [15:0] d);
        logic acc;
        int   lim;
        int   np;
        acc = i_v && m_ir(k, depth, o_rdy);
        if (f) begin
            mcnt[k] = 0;
            return;
        end
        if (m_ov(k, depth) && o_rdy) begin
            for (int j = 0; j < mcnt[k] - 1; j++) begin
                mpos[k][j] = mpos[k][j+1];
                mdat[k][j] = mdat[k][j+1];
            end
            mcnt[k]--;
        end
        // Each word moves one stage forward unless the word ahead blocks it.
        lim = depth - 1;
        for (int j = 0; j < mcnt[k]; j++) begin
            np = (mpos[k][j] + 1 < lim) ? mpos[k][j] + 1 : lim;
            mpos[k][j] = np;
            lim = np - 1;
        end
        if (acc) begin
            if (lim < 0) $display("FAIL model_entry: no free stage 0 for depth %0d", depth);
            mpos[k][mcnt[k]] = 0;
            mdat[k][mcnt[k]] = d;
            mcnt[k]++;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcnt[0] = 0;
            mcnt[1] = 0;
        end else begin
            model_step(0, 3, iv, orr, fl, id);
            model_step(1, 1, iv1, or1, 1'b0, id1);
        end
    end

    // Per-cycle comparison of both builds against the model.
    always @(negedge clk) begin
        chk("d3_in_ready",  32'(ir),  32'(m_ir(0, 3, orr)));
        chk("d3_out_valid", 32'(ov),  32'(m_ov(0, 3)));
        chk("d3_count",     32'(cnt), 32'(mcnt[0]));
        if (m_ov(0, 3)) chk("d3_out_data", 32'(od), 32'(mdat[0][0]));
        chk("d1_in_ready",  32'(ir1),  32'(m_ir(1, 1, or1)));
        chk("d1_out_valid", 32'(ov1),  32'(m_ov(1, 1)));
        chk("d1_count",     32'(cnt1), 32'(mcnt[1]));
        if (m_ov(1, 1)) chk("d1_out_data", 32'(od1), 32'(mdat[1][0]));
        if (ov1 && !or1) chk("d1_blocked_when_held", 32'(ir1), 32'(0));
    end

    task automatic cyc();
        @(posedge clk);
        #2;
        or1 = ~or1;
        iv1 = ($urandom_range(0, 3) != 0);
        id1 = 16'($urandom);
    endtask

    initial begin
        reset = 1'b0; iv = 1'b0; orr = 1'b0; fl = 1'b0; id = '0;
        iv1 = 1'b0; or1 = 1'b0; fl1 = 1'b0; id1 = '0;
        #1;
        chk("rst_out_valid", 32'(ov),  32'(0));
        chk("rst_count",     32'(cnt), 32'(0));
        chk("rst_out_data",  32'(od),  32'(16'h0000));
        chk("rst_in_ready",  32'(ir),  32'(1));
        repeat (2) cyc();
        reset = 1'b1;

        // Streaming at full rate
        orr = 1'b1;
        for (int w = 1; w <= 8; w++) begin
            iv = 1'b1;
            id = 16'(w);
            #1;
            if (w >= 4) begin
                chk("stream_valid", 32'(ov),  32'(1));
                chk("stream_data",  32'(od),  32'(w - 3));
                chk("stream_count", 32'(cnt), 32'(3));
            end
            cyc();
        end
        iv = 1'b0;
        repeat (4) cyc();

        // Stall with bubble collapse
        orr = 1'b0;
        for (int w = 0; w < 3; w++) begin
            iv = 1'b1;
            id = 16'hA000 + 16'(w);
            cyc();
            #1;
            chk("stall_count", 32'(cnt), 32'(w + 1));
        end
        id = 16'hA003;
        #1;
        chk("stall_in_ready", 32'(ir), 32'(0));
        cyc();
        #1;
        chk("stall_hold_count", 32'(cnt), 32'(3));
        chk("stall_head",       32'(od),  32'(16'hA000));
        orr = 1'b1;
        #1;
        chk("release_in_ready", 32'(ir), 32'(1));
        cyc();
        iv = 1'b0;
        #1;
        chk("release_head1",  32'(od),  32'(16'hA001));
        chk("release_count",  32'(cnt), 32'(3));
        cyc();
        #1;
        chk("release_head2", 32'(od), 32'(16'hA002));
        cyc();
        #1;
        chk("release_head3", 32'(od), 32'(16'hA003));
        cyc();
        #1;
        chk("release_empty", 32'(ov), 32'(0));

        // Flush on a full, stalled chain with a concurrent input
        orr = 1'b0;
        for (int w = 0; w < 3; w++) begin
            iv = 1'b1;
            id = 16'hC000 + 16'(w);
            cyc();
        end
        id = 16'hBEEF;
        fl = 1'b1;
        cyc();
        fl = 1'b0;
        iv = 1'b0;
        #1;
        chk("flush_count",    32'(cnt), 32'(0));
        chk("flush_valid",    32'(ov),  32'(0));
        chk("flush_in_ready", 32'(ir),  32'(1));
        orr = 1'b1;
        repeat (4) begin
            cyc();
            #1;
            chk("flush_no_beef", 32'(ov), 32'(0));
        end

        // Flush while in_ready is high
        for (int w = 0; w < 2; w++) begin
            iv = 1'b1;
            id = 16'hD000 + 16'(w);
            cyc();
        end
        id = 16'hBEEF;
        fl = 1'b1;
        cyc();
        fl = 1'b0;
        iv = 1'b0;
        #1;
        chk("flush2_count", 32'(cnt), 32'(0));
        repeat (3) begin
            cyc();
            #1;
            chk("flush2_no_beef", 32'(ov), 32'(0));
        end

        // Asynchronous reset mid-stream with two words held
        orr = 1'b0;
        iv = 1'b1;
        id = 16'hE000;
        cyc();
        id = 16'hE001;
        cyc();
        iv = 1'b0;
        #1;
        chk("pre_reset_count", 32'(cnt), 32'(2));
        #4;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", 32'(ov),  32'(0));
        chk("async_rst_count", 32'(cnt), 32'(0));
        chk("async_rst_data",  32'(od),  32'(16'h0000));
        cyc();
        reset = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(ir),  32'(1));
        chk("post_rst_count",    32'(cnt), 32'(0));

        // Random back-pressure
        for (int c = 0; c < 1000; c++) begin
            iv  = 1'($urandom_range(0, 1));
            id  = 16'($urandom);
            orr = 1'($urandom_range(0, 1));
            cyc();
        end
        iv  = 1'b0;
        orr = 1'b1;
        repeat (5) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
